// File: rtl/ofmap_bit_packer.sv
// ofmap_bit_packer
// Collects the 1-bit binarized activations coming out of the threshold stage
// into WORD_WIDTH-bit ofmap words and issues masked BRAM writes. A word is
// written when it fills up, when the bit stream moves to another word, or when
// the layer ends. At end of layer the block reports how many writes it issued.
module ofmap_bit_packer #(
  parameter int BIT_ADDR_WIDTH = 12,
  parameter int WORD_WIDTH     = 32,
  localparam int SEL_W         = $clog2(WORD_WIDTH),
  localparam int WADDR_W       = BIT_ADDR_WIDTH - SEL_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_valid,
  input  logic                      i_bit,
  input  logic [BIT_ADDR_WIDTH-1:0] i_addr,
  input  logic                      i_last,
  output logic                      bram_we,
  output logic [WADDR_W-1:0]        bram_addr,
  output logic [WORD_WIDTH-1:0]     bram_wdata,
  output logic [WORD_WIDTH-1:0]     bram_wmask,
  output logic                      o_layer_done,
  output logic [WADDR_W:0]          o_layer_words
);

  // IDLE   : nothing pending
  // ACCUM  : a partially filled word is held in acc_*
  // FLUSH2 : i_last arrived together with a bit for a new word; that new
  //          word is still owed as a second write
  // DONE   : the final write of the layer is on the BRAM port this cycle;
  //          the completion pulse follows on the next cycle
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    FLUSH2 = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Pending word
  logic [WADDR_W-1:0]    acc_addr,  acc_addr_nxt;
  logic [WORD_WIDTH-1:0] acc_data,  acc_data_nxt;
  logic [WORD_WIDTH-1:0] acc_mask,  acc_mask_nxt;
  logic                  acc_vld;

  // Writes issued so far in the current layer
  logic [WADDR_W:0]      wr_cnt;

  // Decoded write request for the next cycle
  logic                  wr_nxt;
  logic [WADDR_W-1:0]    wr_addr;
  logic [WORD_WIDTH-1:0] wr_data;
  logic [WORD_WIDTH-1:0] wr_mask;
  logic                  done_nxt;
  logic                  layer_close;

  // Incoming bit decode
  logic [WADDR_W-1:0]    in_word;
  logic [SEL_W-1:0]      in_pos;
  logic [WORD_WIDTH-1:0] in_onehot;
  logic [WORD_WIDTH-1:0] in_data;
  logic                  take;
  logic                  same_word;
  logic                  word_change;
  logic                  is_full;
  logic [WORD_WIDTH-1:0] merged_data;
  logic [WORD_WIDTH-1:0] merged_mask;

  assign in_word   = i_addr[BIT_ADDR_WIDTH-1:SEL_W];
  assign in_pos    = i_addr[SEL_W-1:0];
  assign in_onehot = WORD_WIDTH'(1) << in_pos;
  assign in_data   = i_bit ? in_onehot : '0;

  // A word is pending in ACCUM, and the owed second word is pending in FLUSH2.
  assign acc_vld   = (state == ACCUM) || (state == FLUSH2);

  // Bits arriving during FLUSH2/DONE are outside the protocol and are dropped.
  assign take        = i_valid && ((state == IDLE) || (state == ACCUM));
  assign same_word   = acc_vld && (in_word == acc_addr);
  assign word_change = take && acc_vld && !same_word;
  assign is_full     = (in_pos == SEL_W'(WORD_WIDTH - 1));

  // Pending word with the incoming bit folded in; a repeated position simply
  // overwrites its data bit. With no pending word the base is empty.
  assign merged_data = ((same_word ? acc_data : '0) & ~in_onehot) | in_data;
  assign merged_mask = (same_word ? acc_mask : '0) | in_onehot;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, ACCUM: begin
        if (i_last) begin
          if (word_change) begin
            state_nxt = FLUSH2;
          end else if (take || acc_vld) begin
            state_nxt = DONE;
          end else begin
            // Nothing left to write: the completion pulse is issued directly.
            state_nxt = IDLE;
          end
        end else if (take) begin
          // After a word change the new bit is always pending, even at the
          // last position, because only one write can go out per cycle.
          state_nxt = (word_change || !is_full) ? ACCUM : IDLE;
        end
      end
      FLUSH2:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / datapath decode: what to write next cycle and how acc evolves
  always_comb begin
    wr_nxt       = 1'b0;
    wr_addr      = acc_addr;
    wr_data      = acc_data;
    wr_mask      = acc_mask;
    acc_addr_nxt = acc_addr;
    acc_data_nxt = acc_data;
    acc_mask_nxt = acc_mask;
    done_nxt     = 1'b0;
    layer_close  = 1'b0;
    unique case (state)
      IDLE, ACCUM: begin
        if (take) begin
          if (word_change) begin
            // Old word goes out; the new bit starts a fresh single-bit word.
            wr_nxt       = 1'b1;
            acc_addr_nxt = in_word;
            acc_data_nxt = in_data;
            acc_mask_nxt = in_onehot;
          end else if (is_full || i_last) begin
            // Word completes with this bit: write the merged result directly.
            wr_nxt       = 1'b1;
            wr_addr      = in_word;
            wr_data      = merged_data;
            wr_mask      = merged_mask;
            acc_data_nxt = '0;
            acc_mask_nxt = '0;
          end else begin
            acc_addr_nxt = in_word;
            acc_data_nxt = merged_data;
            acc_mask_nxt = merged_mask;
          end
        end else if (i_last) begin
          if (acc_vld) begin
            wr_nxt       = 1'b1;
            acc_data_nxt = '0;
            acc_mask_nxt = '0;
          end else begin
            done_nxt    = 1'b1;
            layer_close = 1'b1;
          end
        end
      end
      FLUSH2: begin
        wr_nxt       = 1'b1;
        acc_data_nxt = '0;
        acc_mask_nxt = '0;
      end
      DONE: begin
        done_nxt    = 1'b1;
        layer_close = 1'b1;
      end
      default: begin
        acc_data_nxt = '0;
        acc_mask_nxt = '0;
      end
    endcase
  end

  // Pending word storage; reset discards any partially filled word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_addr <= '0;
      acc_data <= '0;
      acc_mask <= '0;
    end else begin
      acc_addr <= acc_addr_nxt;
      acc_data <= acc_data_nxt;
      acc_mask <= acc_mask_nxt;
    end
  end

  // Registered BRAM write port; address/data/mask hold between writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bram_we    <= 1'b0;
      bram_addr  <= '0;
      bram_wdata <= '0;
      bram_wmask <= '0;
    end else begin
      bram_we <= wr_nxt;
      if (wr_nxt) begin
        bram_addr  <= wr_addr;
        bram_wdata <= wr_data;
        bram_wmask <= wr_mask;
      end
    end
  end

  // Per-layer write count and completion report
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt        <= '0;
      o_layer_done  <= 1'b0;
      o_layer_words <= '0;
    end else begin
      o_layer_done <= done_nxt;
      if (layer_close) begin
        // No write is issued in a closing cycle, so the count is final here.
        o_layer_words <= wr_cnt;
        wr_cnt        <= '0;
      end else if (wr_nxt) begin
        wr_cnt <= wr_cnt + (WADDR_W + 1)'(1);
      end
    end
  end

endmodule
